// File: rtl/led_seq_ctrl_if.sv
// Command/status bundle for the LED sequencer: command handshake, abort and PWM status.
interface led_seq_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_mode;
  logic [7:0]  cmd_reps;
  logic        abort;
  logic        led;
  logic [11:0] duty;
  logic        busy;
  logic        done;

  modport master (
    output cmd_valid, cmd_mode, cmd_reps, abort,
    input  cmd_ready, led, duty, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_reps, abort,
    output cmd_ready, led, duty, busy, done
  );
endinterface

// File: rtl/led_seq_ctrl.sv
// LED PWM sequencer: free-running PWM period counter plus an FSM that ramps or
// blinks the duty cycle for a commanded number of repetitions.
module led_seq_ctrl #(
  parameter int unsigned CNT_NUM      = 2400,
  parameter int unsigned HOLD_PERIODS = 100
) (
  input logic           clk,
  input logic           rst,
  led_seq_ctrl_if.slave bus
);

  localparam logic [11:0] DutyFull = 12'(CNT_NUM);
  localparam logic [11:0] PcntLast = 12'(CNT_NUM - 1);
  localparam logic [7:0]  HoldLast = 8'(HOLD_PERIODS - 1);

  localparam logic [1:0] ModeOff    = 2'd0;
  localparam logic [1:0] ModeOn     = 2'd1;
  localparam logic [1:0] ModeBreath = 2'd2;
  localparam logic [1:0] ModeBlink  = 2'd3;

  typedef enum logic [2:0] {StIdle, StUp, StHoldHi, StDown, StHoldLo} state_e;

  state_e      state_q, state_d;
  logic [11:0] pcnt_q;
  logic [11:0] duty_q, duty_d;
  logic [7:0]  rc_q, rc_d;
  logic [7:0]  hc_q, hc_d;
  logic [7:0]  reps_q, reps_d;
  logic [1:0]  mode_q, mode_d;
  logic        done_q, done_d;

  logic period_end;
  logic accept;
  logic hold_last;
  logic last_rep;

  assign period_end = (pcnt_q == PcntLast);
  assign accept     = bus.cmd_valid && bus.cmd_ready;
  assign hold_last  = (hc_q == HoldLast);
  // reps_q == 0 never matches, so rc simply wraps and the sequence runs forever.
  assign last_rep   = (reps_q != 8'd0) && ((rc_q + 8'd1) == reps_q);

  always_ff @(posedge clk) begin
    if (rst || period_end) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + 12'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    rc_d    = rc_q;
    hc_d    = hc_q;
    mode_d  = mode_q;
    reps_d  = reps_q;
    done_d  = 1'b0;

    if (state_q != StIdle && bus.abort) begin
      state_d = StIdle;
      duty_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            mode_d = bus.cmd_mode;
            reps_d = bus.cmd_reps;
            rc_d   = '0;
            hc_d   = '0;
            case (bus.cmd_mode)
              ModeOff: begin
                duty_d = '0;
                done_d = 1'b1;
              end
              ModeOn: begin
                duty_d = DutyFull;
                done_d = 1'b1;
              end
              ModeBreath: begin
                duty_d  = '0;
                state_d = StUp;
              end
              ModeBlink: begin
                duty_d  = DutyFull;
                state_d = StHoldHi;
              end
            endcase
          end
        end
        StUp: begin
          if (period_end) begin
            duty_d = duty_q + 12'd1;
            if (duty_q == DutyFull - 12'd1) begin
              state_d = StHoldHi;
              hc_d    = '0;
            end
          end
        end
        StHoldHi: begin
          if (period_end) begin
            if (hold_last) begin
              hc_d = '0;
              if (mode_q == ModeBlink) begin
                state_d = StHoldLo;
                duty_d  = '0;
              end else begin
                state_d = StDown;
              end
            end else begin
              hc_d = hc_q + 8'd1;
            end
          end
        end
        StDown: begin
          if (period_end) begin
            duty_d = duty_q - 12'd1;
            if (duty_q == 12'd1) begin
              state_d = StHoldLo;
              hc_d    = '0;
            end
          end
        end
        StHoldLo: begin
          if (period_end) begin
            if (hold_last) begin
              hc_d = '0;
              rc_d = rc_q + 8'd1;
              if (last_rep) begin
                state_d = StIdle;
                done_d  = 1'b1;
              end else if (mode_q == ModeBlink) begin
                state_d = StHoldHi;
                duty_d  = DutyFull;
              end else begin
                state_d = StUp;
              end
            end else begin
              hc_d = hc_q + 8'd1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      duty_q  <= '0;
      rc_q    <= '0;
      hc_q    <= '0;
      mode_q  <= ModeOff;
      reps_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      rc_q    <= rc_d;
      hc_q    <= hc_d;
      mode_q  <= mode_d;
      reps_q  <= reps_d;
      done_q  <= done_d;
    end
  end

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.duty      = duty_q;
  assign bus.done      = done_q;
  // Active-low PWM output.
  assign bus.led       = !(pcnt_q < duty_q);

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: per-cycle comparison against a schedule-based model
// plus directed scenarios with literal expectations.
module tb_led_seq_ctrl;
  localparam int N = 8;
  localparam int H = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  led_seq_ctrl_if bus();

  led_seq_ctrl #(
    .CNT_NUM     (N),
    .HOLD_PERIODS(H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  // Model: the sequence is a list of duty values, one per period end.
  int       m_pcnt = 0;
  int       m_duty = 0;
  int       m_left = 0;
  bit       m_busy = 1'b0;
  bit       m_done = 1'b0;
  int       m_mode = 0;
  int       m_seq[$];
  bit       chk_en = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic void fill(int mode);
    if (mode == 2) begin
      for (int i = 1; i <= N; i++) m_seq.push_back(i);
      for (int i = 0; i < H; i++) m_seq.push_back(N);
      for (int i = N - 1; i >= 0; i--) m_seq.push_back(i);
      for (int i = 0; i < H; i++) m_seq.push_back(0);
    end else begin
      for (int i = 0; i < H - 1; i++) m_seq.push_back(N);
      m_seq.push_back(0);
      for (int i = 0; i < H; i++) m_seq.push_back(0);
    end
  endfunction

  task automatic model_step();
    bit pe;
    bit dn;
    dn = 1'b0;
    if (rst) begin
      m_pcnt = 0;
      m_duty = 0;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_seq.delete();
      return;
    end
    pe = (m_pcnt == N - 1);
    if (!m_busy) begin
      if (bus.cmd_valid) begin
        m_mode = int'(bus.cmd_mode);
        m_left = int'(bus.cmd_reps);
        m_seq.delete();
        case (m_mode)
          0: begin m_duty = 0; dn = 1'b1; end
          1: begin m_duty = N; dn = 1'b1; end
          2: begin m_duty = 0; m_busy = 1'b1; fill(2); end
          default: begin m_duty = N; m_busy = 1'b1; fill(3); end
        endcase
      end
    end else if (bus.abort) begin
      m_busy = 1'b0;
      m_duty = 0;
      m_seq.delete();
    end else if (pe) begin
      m_duty = m_seq.pop_front();
      if (m_seq.size() == 0) begin
        if (m_left == 1) begin
          m_busy = 1'b0;
          dn     = 1'b1;
        end else begin
          if (m_left > 1) m_left--;
          fill(m_mode);
          if (m_mode == 3) m_duty = N;
        end
      end
    end
    m_pcnt = pe ? 0 : m_pcnt + 1;
    m_done = dn;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("duty", bus.duty, m_duty);
      chk("led", bus.led, (m_pcnt < m_duty) ? 0 : 1);
      chk("busy", bus.busy, m_busy);
      chk("done", bus.done, m_done);
      chk("cmd_ready", bus.cmd_ready, !m_busy);
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(logic [1:0] mode, logic [7:0] reps);
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = mode;
    bus.cmd_reps  = reps;
    tick(1);
    bus.cmd_valid = 1'b0;
  endtask

  // Leaves the bench in the last cycle of a PWM period.
  task automatic align();
    int g = 0;
    while (m_pcnt != N - 1 && g < 2 * N) begin
      tick(1);
      g++;
    end
  endtask

  task automatic run_breath();
    int q[$];
    int pe = 0;
    int dcnt = 0;
    int dpe = -1;
    int exp_d[20] = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 8, 7, 6, 5, 4, 3, 2, 1, 0, 0, 0};
    send(2'd2, 8'd1);
    for (int c = 0; c < 400 && pe < 22; c++) begin
      if (c > 0 && m_pcnt == 0) begin
        pe++;
        if (pe <= 20) q.push_back(int'(bus.duty));
      end
      if (bus.done) begin
        dcnt++;
        dpe = pe;
      end
      tick(1);
    end
    chk("breath_periods", pe, 22);
    chk("breath_len", q.size(), 20);
    for (int i = 0; i < 20 && i < q.size(); i++) chk($sformatf("breath_duty[%0d]", i), q[i], exp_d[i]);
    chk("breath_done_cnt", dcnt, 1);
    chk("breath_done_pe", dpe, 20);
    chk("breath_busy_end", bus.busy, 0);
  endtask

  task automatic run_blink();
    int q[$];
    int runs[$];
    int pe = 0;
    int cur = 0;
    int dcnt = 0;
    int dpe = -1;
    int exp_d[8] = '{8, 0, 0, 8, 8, 0, 0, 0};
    align();
    send(2'd3, 8'd2);
    for (int c = 0; c < 200 && pe < 10; c++) begin
      if (c > 0 && m_pcnt == 0) begin
        pe++;
        if (pe <= 8) q.push_back(int'(bus.duty));
      end
      if (!bus.led) cur++;
      else if (cur > 0) begin
        runs.push_back(cur);
        cur = 0;
      end
      if (bus.done) begin
        dcnt++;
        dpe = pe;
      end
      tick(1);
    end
    chk("blink_periods", pe, 10);
    chk("blink_len", q.size(), 8);
    for (int i = 0; i < 8 && i < q.size(); i++) chk($sformatf("blink_duty[%0d]", i), q[i], exp_d[i]);
    chk("blink_low_runs", runs.size(), 2);
    for (int i = 0; i < runs.size(); i++) chk($sformatf("blink_low_len[%0d]", i), runs[i], 16);
    chk("blink_done_cnt", dcnt, 1);
    chk("blink_done_pe", dpe, 8);
  endtask

  task automatic run_onoff();
    int dcnt = 0;
    int lhi = 0;
    int llo = 0;
    int bsy = 0;
    send(2'd1, 8'd0);
    for (int c = 0; c < 20; c++) begin
      if (bus.done) dcnt++;
      if (bus.led) lhi++;
      if (bus.busy) bsy++;
      tick(1);
    end
    chk("on_done_cnt", dcnt, 1);
    chk("on_led_high", lhi, 0);
    chk("on_busy", bsy, 0);
    chk("on_duty", bus.duty, 8);
    dcnt = 0;
    bsy  = 0;
    send(2'd0, 8'd0);
    for (int c = 0; c < 20; c++) begin
      if (bus.done) dcnt++;
      if (!bus.led) llo++;
      if (bus.busy) bsy++;
      tick(1);
    end
    chk("off_done_cnt", dcnt, 1);
    chk("off_led_low", llo, 0);
    chk("off_busy", bsy, 0);
    chk("off_duty", bus.duty, 0);
  endtask

  task automatic run_abort();
    int pe = 0;
    send(2'd2, 8'd0);
    for (int c = 0; c < 300 && pe < 12; c++) begin
      tick(1);
      if (m_pcnt == 0) pe++;
    end
    chk("abort_reach", pe, 12);
    align();
    chk("abort_pre_duty", bus.duty, 6);
    chk("abort_pre_busy", bus.busy, 1);
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    chk("abort_duty", bus.duty, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_ready", bus.cmd_ready, 1);
    send(2'd1, 8'd0);
    chk("abort_next_duty", bus.duty, 8);
    chk("abort_next_done", bus.done, 1);
    send(2'd0, 8'd0);
    tick(2);
  endtask

  task automatic run_rst();
    int low = 0;
    send(2'd3, 8'd0);
    tick(5);
    chk("rst_pre_busy", bus.busy, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = 2'd1;
    bus.cmd_reps  = 8'd0;
    rst = 1'b1;
    tick(1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_duty", bus.duty, 0);
    chk("rst_led", bus.led, 1);
    chk("rst_done", bus.done, 0);
    rst = 1'b0;
    tick(1);
    bus.cmd_valid = 1'b0;
    chk("rst_acc_duty", bus.duty, 8);
    chk("rst_acc_done", bus.done, 1);
    // Period counter restarted at the reset edge: blink now lasts 14 cycles.
    send(2'd3, 8'd1);
    for (int c = 0; c < 40; c++) begin
      if (!bus.led) low++;
      tick(1);
    end
    chk("rst_pcnt_phase", low, 14);
    chk("rst_end_busy", bus.busy, 0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_mode  = 2'd0;
    bus.cmd_reps  = 8'd0;
    bus.abort     = 1'b0;
    rst           = 1'b1;
    tick(1);
    chk_en = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(50);
    chk("idle_led", bus.led, 1);
    chk("idle_duty", bus.duty, 0);
    chk("idle_ready", bus.cmd_ready, 1);
    chk("idle_busy", bus.busy, 0);
    run_breath();
    run_blink();
    run_onoff();
    run_abort();
    run_rst();
    tick(3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 SHALL have parameter CNT_NUM, default 2400, which is both the PWM period in clk cycles and the full-scale duty (range 2..4095).
REQ-002 SHALL have parameter HOLD_PERIODS, default 100, which is the number of PWM periods spent in each hold state (range 1..255).
REQ-003 SHALL have port clk, input, 1 bit: system clock; the block uses this single clock domain only.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-006 SHALL have port cmd_ready, output, 1 bit: the block can accept a command.
REQ-007 SHALL have port cmd_mode, input, 2 bits: 0=OFF, 1=ON, 2=BREATH, 3=BLINK.
REQ-008 SHALL have port cmd_reps, input, 8 bits: repetition count; 0 means run forever.
REQ-009 SHALL have port abort, input, 1 bit: stops the running sequence.
REQ-010 SHALL have port led, output, 1 bit: PWM output, active-low.
REQ-011 SHALL have port duty, output, 12 bits: current duty value.
REQ-012 SHALL have port busy, output, 1 bit: high when the FSM is in any state other than IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when a command completes.

Function
REQ-014 SHALL run a free-running period counter pcnt over 0..CNT_NUM-1 that wraps to 0; commands never restart it.
REQ-015 SHALL define period_end as pcnt==CNT_NUM-1.
REQ-016 SHALL drive led combinationally as 0 when pcnt<duty, else 1. With duty=0, led stays 1; with duty=CNT_NUM, led stays 0.
REQ-017 SHALL assert cmd_ready only in IDLE and SHALL accept a command on cmd_valid&&cmd_ready, latching cmd_mode and cmd_reps.
REQ-018 SHALL implement FSM states IDLE, UP, HOLD_HI, DOWN and HOLD_LO.
REQ-019 SHALL handle OFF/ON accept as follows: duty<=0 (OFF) or duty<=CNT_NUM (ON) on the next edge, FSM stays in IDLE, and done pulses on the next cycle.
REQ-020 SHALL handle BREATH accept as follows: duty<=0, repetition counter rc<=0, and the FSM goes to UP.
REQ-021 SHALL handle BLINK accept as follows: duty<=CNT_NUM, rc<=0, and the FSM goes to HOLD_HI.
REQ-022 SHALL, in UP, increment duty by 1 at each period_end; when the incremented value equals CNT_NUM, the FSM goes to HOLD_HI with hold counter hc<=0.
REQ-023 SHALL, in HOLD_HI, increment hc at each period_end; at the HOLD_PERIODS-th period_end it goes to DOWN (BREATH) or to HOLD_LO with duty<=0 (BLINK), and hc<=0.
REQ-024 SHALL, in DOWN, decrement duty by 1 at each period_end; when the decremented value equals 0, the FSM goes to HOLD_LO with hc<=0.
REQ-025 SHALL, in HOLD_LO, count HOLD_PERIODS period_ends and then end the repetition with rc<=rc+1.
REQ-026 SHALL, at the end of a repetition, go to IDLE and pulse done if cmd_reps!=0 and rc+1==cmd_reps; otherwise it SHALL go to UP (BREATH) or to HOLD_HI with duty<=CNT_NUM (BLINK).
REQ-027 SHALL keep rc at 8 bits and SHALL let it wrap freely when cmd_reps=0.
REQ-028 SHALL never let duty leave the range 0..CNT_NUM; duty updates happen only at period_end or on command accept/abort.
REQ-029 SHALL, on abort in a non-IDLE state, go to IDLE with duty<=0 on the next edge and SHALL NOT pulse done; abort takes priority over a simultaneous period_end transition.
REQ-030 SHALL ignore abort in IDLE, so a cmd_valid in the same cycle is still accepted.
REQ-031 SHALL hold busy at 1 from the cycle after a BREATH/BLINK accept until the cycle after the return to IDLE.

Reset
REQ-032 SHALL, while rst is high at a clk edge, set pcnt=0, duty=0, state=IDLE, rc=0, hc=0 and done=0; outputs are then led=1, busy=0, cmd_ready=1.
REQ-033 SHALL let reset asserted mid-sequence override abort and commands and return the block to the REQ-032 values on the next edge.

Verification (CNT_NUM=8, HOLD_PERIODS=2)
REQ-034 SHALL cover: reset, then idle for 50 cycles -> led=1, duty=0, cmd_ready=1, busy=0 throughout.
REQ-035 SHALL cover: BREATH with reps=1 -> duty steps 1..8 on successive period_ends, holds 2 periods, steps 7..0, holds 2 periods; done pulses once after the 20th period_end; busy then drops.
REQ-036 SHALL cover: BLINK with reps=2 -> duty alternates 8,0,8,0 with 2 periods each; led low exactly 16 cycles per high phase; a single done pulse after the 8th period_end.
REQ-037 SHALL cover: ON, then OFF -> duty=8 with led constantly 0, then duty=0 with led constantly 1; each command gives a one-cycle done, and busy never rises.
REQ-038 SHALL cover: BREATH with reps=0, abort during DOWN coinciding with period_end -> IDLE and duty=0 next cycle, no done, and a new command is accepted the following cycle.
REQ-039 SHALL cover: rst pulsed during HOLD_HI while cmd_valid is held high -> state IDLE, duty 0 and pcnt 0 after the edge; the command is accepted on the first cycle after rst falls.
